bus_handshake_slice: RTL and testbench

Parameterized valid/ready register slice for point-to-point streaming buses, placed between a producer (upstream) and a consumer (downstream). A build-time MODE parameter selects one of three variants. SYN is a combinational pass-through. VALID_FLOP registers the forward path (valid and data). READY_FLOP registers the backward path (ready) using a one-entry skid buffer. All modes are lossless and order-preserving: every beat accepted upstream is delivered downstream exactly once, in order.

---
 rtl/bus_handshake_slice.sv | 90 +++++++++
 tb/tb_bus_handshake_slice.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bus_handshake_slice.sv
// Valid/ready register slice: MODE 0 = combinational pass-through,
// MODE 1 = registered forward path, MODE 2 = registered ready via one-entry skid buffer.
module bus_handshake_slice #(
    parameter int WIDTH = 32,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (MODE == 0) begin : g_syn
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rstn};

            assign valid_o = valid_i;
            assign ready_o = ready_i;
            assign data_o  = data_i;
        end else if (MODE == 1) begin : g_valid_flop
            logic             v_q, v_d;
            logic [WIDTH-1:0] d_q, d_d;
            logic             accept;

            // Register may refill on the same edge it drains.
            assign accept  = ready_i || !v_q;
            assign ready_o = accept;
            assign valid_o = v_q;
            assign data_o  = d_q;

            always_comb begin
                v_d = v_q;
                d_d = d_q;
                if (accept) begin
                    v_d = valid_i;
                    if (valid_i) begin
                        d_d = data_i;
                    end
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    v_q <= 1'b0;
                    d_q <= '0;
                end else begin
                    v_q <= v_d;
                    d_q <= d_d;
                end
            end
        end else if (MODE == 2) begin : g_ready_flop
            logic             skid_v_q, skid_v_d;
            logic [WIDTH-1:0] skid_d_q, skid_d_d;

            assign ready_o = !skid_v_q;
            assign valid_o = valid_i || skid_v_q;
            assign data_o  = skid_v_q ? skid_d_q : data_i;

            // ready_o is low while the skid is full, so fill and drain never coincide.
            always_comb begin
                skid_v_d = skid_v_q;
                skid_d_d = skid_d_q;
                if (skid_v_q && ready_i) begin
                    skid_v_d = 1'b0;
                end else if (valid_i && !skid_v_q && !ready_i) begin
                    skid_v_d = 1'b1;
                    skid_d_d = data_i;
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    skid_v_q <= 1'b0;
                    skid_d_q <= '0;
                end else begin
                    skid_v_q <= skid_v_d;
                    skid_d_q <= skid_d_d;
                end
            end
        end else begin : g_bad_mode
            $error("bus_handshake_slice: illegal MODE %0d (must be 0, 1 or 2)", MODE);
        end
    endgenerate

endmodule

// File: tb/tb_bus_handshake_slice.sv
// Bench for bus_handshake_slice: one instance per MODE, directed vector table,
// mid-operation reset sequence, and a randomized order/stability scoreboard.
module tb_bus_handshake_slice;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         v_in [3];
    logic         r_in [3];
    logic [W-1:0] d_in [3];
    logic         vo   [3];
    logic         ro   [3];
    logic [W-1:0] dout [3];

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    bus_handshake_slice #(.WIDTH(W), .MODE(0)) u_syn (
        .clk(clk), .rstn(rstn), .valid_i(v_in[0]), .ready_o(ro[0]),
        .valid_o(vo[0]), .ready_i(r_in[0]), .data_i(d_in[0]), .data_o(dout[0]));
    bus_handshake_slice #(.WIDTH(W), .MODE(1)) u_vf (
        .clk(clk), .rstn(rstn), .valid_i(v_in[1]), .ready_o(ro[1]),
        .valid_o(vo[1]), .ready_i(r_in[1]), .data_i(d_in[1]), .data_o(dout[1]));
    bus_handshake_slice #(.WIDTH(W), .MODE(2)) u_rf (
        .clk(clk), .rstn(rstn), .valid_i(v_in[2]), .ready_o(ro[2]),
        .valid_o(vo[2]), .ready_i(r_in[2]), .data_i(d_in[2]), .data_o(dout[2]));

    typedef struct {
        int           mode;
        logic         rstn;
        logic         v;
        logic         r;
        logic [W-1:0] d;
        logic         ev;
        logic         er;
        logic [W-1:0] ed;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic idle_all();
        for (int m = 0; m < 3; m++) begin
            v_in[m] = 1'b0;
            r_in[m] = 1'b0;
            d_in[m] = '0;
        end
    endtask

    task automatic run_random(input int m);
        logic         hold  = 1'b0;
        logic         stall = 1'b0;
        logic [W-1:0] last_d = '0;
        logic         up, dn;
        logic [W-1:0] q[$];
        for (int cyc = 0; cyc < 1020; cyc++) begin
            @(negedge clk);
            if (!hold) begin
                v_in[m] = (cyc >= 1000) ? 1'b0 : 1'($urandom);
                d_in[m] = W'($urandom);
            end
            r_in[m] = (cyc >= 1000) ? 1'b1 : ($urandom_range(3) != 0);
            #1;
            if (stall) begin
                chk($sformatf("m%0d stall_valid", m), {31'd0, vo[m]}, 32'd1);
                chk($sformatf("m%0d stall_data", m), {24'd0, dout[m]}, {24'd0, last_d});
            end
            up = v_in[m] && ro[m];
            dn = vo[m] && r_in[m];
            if (up) q.push_back(d_in[m]);
            if (dn) begin
                if (q.size() == 0) chk($sformatf("m%0d underflow", m), 32'd1, 32'd0);
                else chk($sformatf("m%0d order", m), {24'd0, dout[m]}, {24'd0, q.pop_front()});
            end
            hold   = v_in[m] && !up;
            stall  = vo[m] && !r_in[m];
            last_d = dout[m];
        end
        chk($sformatf("m%0d drained", m), q.size(), 32'd0);
        idle_all();
    endtask

    initial begin
        idle_all();

        // {mode, rstn, valid_i, ready_i, data_i, exp valid_o, exp ready_o, exp data_o}
        vecs.push_back('{0, 1'b0, 1'b1, 1'b0, 8'd6,  1'b1, 1'b0, 8'd6});
        vecs.push_back('{0, 1'b0, 1'b0, 1'b1, 8'd16, 1'b0, 1'b1, 8'd16});
        vecs.push_back('{1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 8'd0});
        vecs.push_back('{2, 1'b0, 1'b1, 1'b0, 8'd6,  1'b1, 1'b1, 8'd6});
        vecs.push_back('{0, 1'b1, 1'b1, 1'b1, 8'd16, 1'b1, 1'b1, 8'd16});
        vecs.push_back('{0, 1'b1, 1'b0, 1'b0, 8'd6,  1'b0, 1'b0, 8'd6});
        // VALID_FLOP streaming then backpressure
        vecs.push_back('{1, 1'b1, 1'b1, 1'b1, 8'd6,  1'b0, 1'b1, 8'd0});
        vecs.push_back('{1, 1'b1, 1'b1, 1'b1, 8'd16, 1'b1, 1'b1, 8'd6});
        vecs.push_back('{1, 1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 8'd16});
        vecs.push_back('{1, 1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 8'd16});
        vecs.push_back('{1, 1'b1, 1'b0, 1'b1, 8'd0,  1'b1, 1'b1, 8'd16});
        vecs.push_back('{1, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 8'd16});
        // READY_FLOP skid fill, hold, drain, then direct path
        vecs.push_back('{2, 1'b1, 1'b1, 1'b0, 8'd6,  1'b1, 1'b1, 8'd6});
        vecs.push_back('{2, 1'b1, 1'b1, 1'b0, 8'd16, 1'b1, 1'b0, 8'd6});
        vecs.push_back('{2, 1'b1, 1'b1, 1'b1, 8'd16, 1'b1, 1'b0, 8'd6});
        vecs.push_back('{2, 1'b1, 1'b1, 1'b1, 8'd16, 1'b1, 1'b1, 8'd16});
        vecs.push_back('{2, 1'b1, 1'b0, 1'b1, 8'd0,  1'b0, 1'b1, 8'd0});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            idle_all();
            rstn             = vecs[i].rstn;
            v_in[vecs[i].mode] = vecs[i].v;
            r_in[vecs[i].mode] = vecs[i].r;
            d_in[vecs[i].mode] = vecs[i].d;
            #1;
            chk($sformatf("vec%0d valid_o", i), {31'd0, vo[vecs[i].mode]}, {31'd0, vecs[i].ev});
            chk($sformatf("vec%0d ready_o", i), {31'd0, ro[vecs[i].mode]}, {31'd0, vecs[i].er});
            chk($sformatf("vec%0d data_o", i), {24'd0, dout[vecs[i].mode]}, {24'd0, vecs[i].ed});
        end

        // Mid-operation reset: VALID_FLOP holds 16, READY_FLOP holds skid beat 6
        @(negedge clk);
        idle_all();
        v_in[1] = 1'b1; r_in[1] = 1'b1; d_in[1] = 8'd16;
        v_in[2] = 1'b1; r_in[2] = 1'b0; d_in[2] = 8'd6;
        @(negedge clk);
        idle_all();
        d_in[2] = 8'h5A;
        #1;
        chk("pre_rst vf valid", {31'd0, vo[1]}, 32'd1);
        chk("pre_rst vf data", {24'd0, dout[1]}, 32'd16);
        chk("pre_rst rf ready", {31'd0, ro[2]}, 32'd0);
        chk("pre_rst rf data", {24'd0, dout[2]}, 32'd6);
        #1;
        rstn = 1'b0;
        #1;
        chk("rst vf valid", {31'd0, vo[1]}, 32'd0);
        chk("rst vf data", {24'd0, dout[1]}, 32'd0);
        chk("rst vf ready", {31'd0, ro[1]}, 32'd1);
        chk("rst rf ready", {31'd0, ro[2]}, 32'd1);
        chk("rst rf valid", {31'd0, vo[2]}, 32'd0);
        chk("rst rf data", {24'd0, dout[2]}, 32'h5A);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst rf valid", {31'd0, vo[2]}, 32'd0);
        chk("post_rst vf valid", {31'd0, vo[1]}, 32'd0);

        for (int m = 0; m < 3; m++) run_random(m);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
